// File: rtl/crc_pkg.sv
// Shared CRC-32 definitions used by both the generator and the checker.
package crc_pkg;

  localparam int              CRC_W      = 32;
  localparam logic [CRC_W-1:0] CRC32_POLY = 32'h04C11DB7;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

endpackage

// File: rtl/crc_32_chk_if.sv
// Codeword-in / result-out handshake bundle of the CRC-32 checker.
interface crc_32_chk_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
);
  import crc_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W+CRC_W-1:0] codeword_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       data_out;
  logic                    crc_ok;
  logic [CRC_W-1:0]        syndrome;
  logic [CNT_W-1:0]        err_cnt;

  modport master (
    output in_valid, codeword_in, out_ready,
    input  in_ready, out_valid, data_out, crc_ok, syndrome, err_cnt
  );

  modport slave (
    input  in_valid, codeword_in, out_ready,
    output in_ready, out_valid, data_out, crc_ok, syndrome, err_cnt
  );

endinterface

// File: rtl/crc_32_div_step.sv
// One MSB-first polynomial division step: shift one codeword bit into the remainder.
module crc_32_div_step
  import crc_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = CRC32_POLY
) (
  input  logic [CRC_W-1:0] rem,
  input  logic             b,
  output logic [CRC_W-1:0] rem_next
);

  for (genvar gi = 0; gi < CRC_W; gi++) begin : g_bit
    if (gi == 0) begin : g_lsb
      assign rem_next[gi] = b ^ (rem[CRC_W-1] & POLY[gi]);
    end else begin : g_upper
      assign rem_next[gi] = rem[gi-1] ^ (rem[CRC_W-1] & POLY[gi]);
    end
  end

endmodule

// File: rtl/crc_32_chk.sv
// Serial CRC-32 checker: divides {data, crc} by POLY, reports syndrome and
// pass/fail, and keeps a saturating count of failed frames.
module crc_32_chk
  import crc_pkg::*;
#(
  parameter int               DATA_W = 16,
  parameter logic [CRC_W-1:0] POLY   = CRC32_POLY,
  parameter int               CNT_W  = 16
) (
  input  logic         clk,
  input  logic         rst,
  crc_32_chk_if.slave  bus
);

  localparam int                   CW_W      = DATA_W + CRC_W;
  localparam int                   BIT_CNT_W = $clog2(CW_W + 1);
  localparam logic [BIT_CNT_W-1:0] CW_BITS   = BIT_CNT_W'(CW_W);

  state_e                 state_q, state_d;
  logic [CW_W-1:0]        shift_q, shift_d;
  logic [CRC_W-1:0]       rem_q, rem_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]      payload_q, payload_d;
  logic                   out_valid_q, out_valid_d;
  logic [DATA_W-1:0]      data_out_q, data_out_d;
  logic                   crc_ok_q, crc_ok_d;
  logic [CRC_W-1:0]       syndrome_q, syndrome_d;
  logic [CNT_W-1:0]       err_cnt_q, err_cnt_d;
  logic [CRC_W-1:0]       rem_step;

  crc_32_div_step #(.POLY(POLY)) u_div_step (
    .rem      (rem_q),
    .b        (shift_q[CW_W-1]),
    .rem_next (rem_step)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    rem_d       = rem_q;
    bit_cnt_d   = bit_cnt_q;
    payload_d   = payload_q;
    out_valid_d = out_valid_q;
    data_out_d  = data_out_q;
    crc_ok_d    = crc_ok_q;
    syndrome_d  = syndrome_q;
    err_cnt_d   = err_cnt_q;

    case (state_q)
      IDLE: begin
        // codeword_in is only sampled on the handshake, so idle-time X never enters state
        if (bus.in_valid) begin
          shift_d   = bus.codeword_in;
          payload_d = bus.codeword_in[CW_W-1:CRC_W];
          rem_d     = '0;
          bit_cnt_d = CW_BITS;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        if (bit_cnt_q == '0) begin
          out_valid_d = 1'b1;
          data_out_d  = payload_q;
          syndrome_d  = rem_q;
          crc_ok_d    = (rem_q == '0);
          state_d     = DONE;
        end else begin
          rem_d     = rem_step;
          shift_d   = {shift_q[CW_W-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q - BIT_CNT_W'(1);
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
          if (!crc_ok_q && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      rem_q       <= '0;
      bit_cnt_q   <= '0;
      payload_q   <= '0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      crc_ok_q    <= 1'b0;
      syndrome_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      rem_q       <= rem_d;
      bit_cnt_q   <= bit_cnt_d;
      payload_q   <= payload_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      crc_ok_q    <= crc_ok_d;
      syndrome_q  <= syndrome_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = data_out_q;
  assign bus.crc_ok    = crc_ok_q;
  assign bus.syndrome  = syndrome_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_crc_32_chk.sv
// Randomized self-checking bench for crc_32_chk; two instances (16-bit and
// 2-bit error counters) see identical stimulus.
module tb_crc_32_chk;
  import crc_pkg::*;

  localparam int DATA_W = 16;
  localparam int CW_W   = DATA_W + CRC_W;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [CW_W-1:0] codeword = '0;

  always #5 clk = ~clk;

  crc_32_chk_if #(.DATA_W(DATA_W), .CNT_W(16)) ifa ();
  crc_32_chk_if #(.DATA_W(DATA_W), .CNT_W(2))  ifb ();

  assign ifa.in_valid    = in_valid;
  assign ifa.codeword_in = codeword;
  assign ifa.out_ready   = out_ready;
  assign ifb.in_valid    = in_valid;
  assign ifb.codeword_in = codeword;
  assign ifb.out_ready   = out_ready;

  crc_32_chk #(.DATA_W(DATA_W), .POLY(CRC32_POLY), .CNT_W(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  crc_32_chk #(.DATA_W(DATA_W), .POLY(CRC32_POLY), .CNT_W(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int exp_err_a = 0;
  int exp_err_b = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Plain GF(2) long division of the whole codeword by x^32 + POLY.
  function automatic logic [31:0] ref_mod(input logic [CW_W-1:0] cw);
    logic [63:0] r;
    logic [63:0] p;
    r = 64'(cw);
    p = {31'b0, 1'b1, CRC32_POLY};
    for (int i = CW_W - 1; i >= CRC_W; i--) begin
      if (r[i]) r = r ^ (p << (i - CRC_W));
    end
    return r[31:0];
  endfunction

  function automatic logic [CW_W-1:0] gen_frame(input logic [DATA_W-1:0] d);
    return {d, ref_mod({d, 32'h0})};
  endfunction

  task automatic accept_frame(input logic [CW_W-1:0] cw, input bit hold_ready);
    int w;
    w = 0;
    @(negedge clk);
    while (!ifa.in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!ifa.in_ready) check_val("accept_timeout", 64'(ifa.in_ready), 64'd1);
    in_valid  = 1'b1;
    codeword  = cw;
    out_ready = hold_ready;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    codeword = {16'($urandom), $urandom};
  endtask

  task automatic run_frame(input logic [CW_W-1:0] cw, input int stall, input string tag);
    logic [31:0] syn;
    int          lat;
    syn = ref_mod(cw);
    accept_frame(cw, stall == 0);
    check_val({tag, "_busy_ready"}, 64'(ifa.in_ready), 64'd0);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!ifa.out_valid && lat < 200);
    check_val({tag, "_latency"}, 64'(lat), 64'd49);
    check_val({tag, "_data"}, 64'(ifa.data_out), 64'(cw[CW_W-1:CRC_W]));
    check_val({tag, "_syndrome"}, 64'(ifa.syndrome), 64'(syn));
    check_val({tag, "_crc_ok"}, 64'(ifa.crc_ok), 64'(syn == 32'h0));
    check_val({tag, "_b_crc_ok"}, 64'(ifb.crc_ok), 64'(syn == 32'h0));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      in_valid = 1'b1;
      codeword = {16'($urandom), $urandom};
      @(posedge clk);
      #1;
      check_val({tag, "_hold_valid"}, 64'(ifa.out_valid), 64'd1);
      check_val({tag, "_hold_ready"}, 64'(ifa.in_ready), 64'd0);
      check_val({tag, "_hold_syn"}, 64'(ifa.syndrome), 64'(syn));
      check_val({tag, "_hold_data"}, 64'(ifa.data_out), 64'(cw[CW_W-1:CRC_W]));
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    if (syn != 32'h0) begin
      if (exp_err_a < 65535) exp_err_a++;
      if (exp_err_b < 3) exp_err_b++;
    end
    check_val({tag, "_released_valid"}, 64'(ifa.out_valid), 64'd0);
    check_val({tag, "_idle_ready"}, 64'(ifa.in_ready), 64'd1);
    check_val({tag, "_err_cnt"}, 64'(ifa.err_cnt), 64'(exp_err_a));
    check_val({tag, "_err_cnt_sat"}, 64'(ifb.err_cnt), 64'(exp_err_b));
    $display("frame %s cw=%012h syndrome=%08h err_a=%0d err_b=%0d", tag, cw, syn, exp_err_a, exp_err_b);
  endtask

  initial begin
    logic [CW_W-1:0] cw;
    logic [DATA_W-1:0] d;

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_in_ready", 64'(ifa.in_ready), 64'd1);
    check_val("rst_out_valid", 64'(ifa.out_valid), 64'd0);
    check_val("rst_data", 64'(ifa.data_out), 64'd0);
    check_val("rst_crc_ok", 64'(ifa.crc_ok), 64'd0);
    check_val("rst_syndrome", 64'(ifa.syndrome), 64'd0);
    check_val("rst_err_cnt", 64'(ifa.err_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_frame(48'h0000_00000000, 0, "zero");
    run_frame({16'h0001, 32'h04C11DB7}, 0, "good1");
    run_frame({16'h0002, 32'h09823B6E}, 0, "good2");
    run_frame({16'h0001, 32'h04C11DB6}, 0, "crc_err");
    run_frame({16'h0000, 32'h04C11DB7}, 0, "data_err");
    run_frame(gen_frame(16'hBEEF) ^ 48'h1, 10, "backpressure");

    for (int i = 0; i < 5; i++) begin
      d = 16'($urandom);
      run_frame(gen_frame(d) ^ 48'h0000_80000000, 0, "bad_sat");
    end
    check_val("sat_b_err_cnt", 64'(ifb.err_cnt), 64'd3);

    for (int i = 0; i < 20; i++) begin
      d  = 16'($urandom);
      cw = gen_frame(d);
      case ($urandom_range(0, 2))
        0:       ;
        1:       cw = cw ^ (48'd1 << $urandom_range(0, CW_W - 1));
        default: cw = {d, $urandom};
      endcase
      run_frame(cw, int'($urandom_range(0, 3)), "rand");
    end

    for (int i = 0; i < 4; i++) begin
      run_frame(gen_frame(16'($urandom)), 0, "loopback");
    end

    accept_frame(gen_frame(16'h1234), 1'b1);
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_err_a = 0;
    exp_err_b = 0;
    check_val("midrst_in_ready", 64'(ifa.in_ready), 64'd1);
    check_val("midrst_out_valid", 64'(ifa.out_valid), 64'd0);
    check_val("midrst_err_cnt", 64'(ifa.err_cnt), 64'd0);
    check_val("midrst_err_cnt_b", 64'(ifb.err_cnt), 64'd0);
    check_val("midrst_syndrome", 64'(ifa.syndrome), 64'd0);
    $display("mid-shift reset applied");
    @(negedge clk);
    rst = 1'b0;
    run_frame(gen_frame(16'hCAFE), 0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
